// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM encoding, default widths, instruction field offsets.
package cpu_pkg;
  localparam int DEF_AW = 64;
  localparam int DEF_IW = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_RELEASE = 2'd2
  } fetch_state_e;

  // Register fields share bits with imm; which ones apply depends on the opcode format.
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 12;
  localparam int R0_LSB  = 12;
  localparam int R1_LSB  = 16;
  localparam int R2_LSB  = 20;
  localparam int R3_LSB  = 24;
  localparam int R4_LSB  = 28;
  localparam int REG_W   = 4;
  localparam int IMM_LSB = 16;
  localparam int IMM_W   = 16;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [DEF_IW-1:0] i);
    return i[OPC_LSB +: OPC_W];
  endfunction
endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module ifq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the ip, masters the RAM txs/txe handshake, prefetches into a queue.
// Optional IFQ_STATS_EN adds saturating fetch/squash counters.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter int            IW         = DEF_IW,
  parameter int            DEPTH      = 4,
  parameter int            ADDR_STEP  = 1,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_txe,
  input  logic          ram_err,
  input  logic [IW-1:0] ram_out,
  output logic          ram_txs,
  output logic          ram_re,
  output logic [AW-1:0] ram_addr,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_addr,
  input  logic          instr_take,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
`ifdef IFQ_STATS_EN
  output logic [31:0]   stat_fetches,
  output logic [31:0]   stat_squashed,
`endif
  output logic          fault,
  output logic [AW-1:0] fault_addr
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      r_state, w_state_nx;
  logic [AW-1:0]     r_fetch_pc, r_addr, r_fault_addr;
  logic              r_txs, r_re, r_squash, r_fault;
  logic              w_issue, w_cap, w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]     w_count;
  logic [IW+AW-1:0]  w_head;

  // Capture is dropped on squash, error or a same-cycle redirect; only a kept capture advances the ip.
  assign w_cap   = (r_state == FETCH_REQ) && ram_txe;
  assign w_push  = w_cap && !r_squash && !ram_err && !redirect;
  assign w_pop   = instr_take && !w_empty && !redirect;
  assign w_issue = (r_state == FETCH_IDLE) && !ram_txe && !r_fault && !w_full && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      FETCH_IDLE:    if (w_issue)  w_state_nx = FETCH_REQ;
      FETCH_REQ:     if (ram_txe)  w_state_nx = FETCH_RELEASE;
      FETCH_RELEASE: if (!ram_txe) w_state_nx = FETCH_IDLE;
      default:                     w_state_nx = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txs        <= 1'b0;
      r_re         <= 1'b0;
      r_addr       <= '0;
      r_fetch_pc   <= RESET_ADDR;
      r_squash     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      if (w_issue) begin
        r_txs  <= 1'b1;
        r_re   <= 1'b1;
        r_addr <= r_fetch_pc;
      end
      if (w_cap) begin
        r_txs <= 1'b0;
        r_re  <= 1'b0;
      end
      if ((r_state == FETCH_RELEASE) && !ram_txe)
        r_squash <= 1'b0;
      else if (redirect && (r_state == FETCH_REQ) && !ram_txe)
        r_squash <= 1'b1;
      if (redirect)    r_fetch_pc <= redirect_addr;
      else if (w_push) r_fetch_pc <= r_fetch_pc + AW'(ADDR_STEP);
      // A wrong-path (squashed) error is not architecturally visible.
      if (redirect) begin
        r_fault <= 1'b0;
      end else if (w_cap && ram_err && !r_squash) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_addr;
      end
    end
  end

  ifq_fifo #(.W(IW + AW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ({ram_out, r_addr}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ram_txs     = r_txs;
  assign ram_re      = r_re;
  assign ram_addr    = r_addr;
  assign instr_valid = (w_count != '0);
  assign instr       = w_head[AW +: IW];
  assign instr_addr  = w_head[AW-1:0];
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetches  <= '0;
      stat_squashed <= '0;
    end else if (w_cap) begin
      if (stat_fetches != '1) stat_fetches <= stat_fetches + 32'd1;
      if ((r_squash || redirect) && stat_squashed != '1) stat_squashed <= stat_squashed + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: a behavioural RAM/fetch model predicts the instruction stream.
module tb_ifetch_queue;
  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ram_txe = 1'b0, ram_err = 1'b0;
  logic [IW-1:0] ram_out = '0;
  logic          ram_txs, ram_re, instr_valid, fault;
  logic [AW-1:0] ram_addr, instr_addr, fault_addr;
  logic [IW-1:0] instr;
  logic          instr_take = 1'b0, redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
`ifdef IFQ_STATS_EN
  logic [31:0]   stat_fetches, stat_squashed;
`endif

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .rst_n(rst_n), .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out),
    .ram_txs(ram_txs), .ram_re(ram_re), .ram_addr(ram_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr), .instr_take(instr_take),
    .redirect(redirect), .redirect_addr(redirect_addr),
`ifdef IFQ_STATS_EN
    .stat_fetches(stat_fetches), .stat_squashed(stat_squashed),
`endif
    .fault(fault), .fault_addr(fault_addr)
  );

  typedef struct { logic [IW-1:0] d; logic [AW-1:0] a; } ent_t;
  typedef enum { R_IDLE, R_WAIT, R_DONE } rs_t;

  int vecs = 0, errs = 0;
  ent_t exp_q[$];
  ent_t pend;
  bit pend_v, flush_pend, mon_en;
  bit exp_fault, nxt_fault, blocked, discard;
  logic [AW-1:0] exp_faddr, nxt_faddr, exp_pc, txn_addr;
  rs_t rs;
  int dly, txn_cnt;
  int take_pct, redir_pct, err_pct, dly_min, dly_max;
  bit take_once, force_redir, cap_redir_once, err_addr_en, redir_on_addr_en;
  logic [AW-1:0] err_addr, redir_trig, redir_tgt;

  function automatic logic [IW-1:0] fdat(input logic [AW-1:0] a);
    logic [AW-1:0] p;
    p = a * 64'h10;
    return p[IW-1:0];
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_v = 0; flush_pend = 0; exp_fault = 0; nxt_fault = 0; blocked = 0; discard = 0;
    exp_faddr = '0; nxt_faddr = '0; exp_pc = '0; rs = R_IDLE; dly = 0;
    ram_txe = 0; ram_err = 0; redirect = 0; instr_take = 0;
  endtask

  // One bench cycle: commit last edge's effects, then play the RAM and choose front-end inputs.
  task automatic step();
    bit do_redir, err;
    logic [AW-1:0] tgt;
    if (flush_pend) begin exp_q.delete(); flush_pend = 0; end
    if (pend_v) begin exp_q.push_back(pend); pend_v = 0; end
    exp_fault = nxt_fault; exp_faddr = nxt_faddr;
    redirect = 0; ram_err = 0;
    instr_take = ($urandom_range(0, 99) < take_pct) || take_once;
    take_once = 0;
    do_redir = ($urandom_range(0, 99) < redir_pct);
    tgt = AW'($urandom_range(0, 200));
    if (force_redir) begin do_redir = 1; tgt = redir_tgt; force_redir = 0; end
    if (redir_on_addr_en && rs == R_WAIT && txn_addr == redir_trig && !discard) begin
      do_redir = 1; tgt = redir_tgt; redir_on_addr_en = 0;
    end
    if (rs == R_IDLE && ram_txs) begin
      check("txs_while_fault", {63'd0, blocked}, '0);
      check("ram_re", {63'd0, ram_re}, 64'd1);
      check("ram_addr", ram_addr, exp_pc);
      txn_addr = exp_pc; discard = 0; txn_cnt++;
      dly = $urandom_range(dly_min, dly_max);
      rs = R_WAIT;
    end else if (rs == R_DONE && !ram_txs) begin
      ram_txe = 0; rs = R_IDLE;
    end
    if (rs == R_WAIT) begin
      if (dly == 0) begin
        if (cap_redir_once) begin do_redir = 1; tgt = redir_tgt; instr_take = 1; cap_redir_once = 0; end
        err = !do_redir && !discard &&
              ((err_addr_en && txn_addr == err_addr) || ($urandom_range(0, 99) < err_pct));
        if (err && err_addr_en && txn_addr == err_addr) err_addr_en = 0;
        ram_txe = 1; ram_err = err; ram_out = fdat(txn_addr); rs = R_DONE;
        if (!do_redir && !discard) begin
          if (err) begin nxt_fault = 1; nxt_faddr = txn_addr; blocked = 1; end
          else begin pend_v = 1; pend.d = fdat(txn_addr); pend.a = txn_addr; exp_pc = exp_pc + 1; end
        end
      end else dly--;
    end
    if (do_redir) begin
      redirect = 1; redirect_addr = tgt; exp_pc = tgt;
      if (rs == R_WAIT) discard = 1;
      flush_pend = 1; nxt_fault = 0; blocked = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin @(negedge clk); #1; step(); end
  endtask

  // Scoreboard monitor: compares the queue head and fault state mid-cycle, pops on a real take.
  always begin
    @(negedge clk); #2;
    if (mon_en) begin
      check("instr_valid", {63'd0, instr_valid}, {63'd0, exp_q.size() > 0});
      if (instr_valid && exp_q.size() > 0) begin
        check("instr", {32'd0, instr}, {32'd0, exp_q[0].d});
        check("instr_addr", instr_addr, exp_q[0].a);
        if (instr_take && !redirect) void'(exp_q.pop_front());
      end
      check("fault", {63'd0, fault}, {63'd0, exp_fault});
      if (exp_fault) check("fault_addr", fault_addr, exp_faddr);
      check("ram_re_eq_txs", {63'd0, ram_re}, {63'd0, ram_txs});
    end
  end

  initial begin
    model_reset();
    txn_cnt = 0; mon_en = 0; take_once = 0; force_redir = 0; cap_redir_once = 0;
    err_addr_en = 0; redir_on_addr_en = 0; err_addr = '0; redir_trig = '0; redir_tgt = '0;
    take_pct = 0; redir_pct = 0; err_pct = 0; dly_min = 2; dly_max = 2;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txs", {63'd0, ram_txs}, '0);
    check("rst_re", {63'd0, ram_re}, '0);
    check("rst_addr", ram_addr, '0);
    check("rst_valid", {63'd0, instr_valid}, '0);
    check("rst_fault", {63'd0, fault}, '0);
    check("rst_fault_addr", fault_addr, '0);
    rst_n = 1; mon_en = 1;

    // Fill to depth with no consumer, then one pop allows exactly one more fetch.
    run(30);
    check("fill_txns", txn_cnt, 4);
    check("fill_txs_low", {63'd0, ram_txs}, '0);
    take_once = 1;
    run(20);
    check("refill_txns", txn_cnt, 5);

    // Continuous consumer drains in order.
    take_pct = 100;
    run(40);

    // Redirect while the fetch two ahead is outstanding.
    redir_trig = exp_pc + 2; redir_tgt = 64'h100; redir_on_addr_en = 1;
    run(40);
    check("redir_req_fired", {63'd0, redir_on_addr_en}, '0);

    // Redirect on the capture cycle together with a take.
    redir_tgt = 64'h40; cap_redir_once = 1;
    run(30);

    // Error on addr 5 with older entries still queued.
    take_pct = 30; dly_min = 1; dly_max = 1;
    redir_tgt = '0; force_redir = 1; err_addr = 64'd5; err_addr_en = 1;
    run(120);
    check("err_fault", {63'd0, fault}, 64'd1);
    check("err_fault_addr", fault_addr, 64'd5);
    take_pct = 100;
    run(20);
    check("err_drained", {63'd0, instr_valid}, '0);
    redir_tgt = 64'd5; force_redir = 1;
    run(30);
    check("err_cleared", {63'd0, fault}, '0);

    // Random mix of timing, takes, redirects and errors.
    take_pct = 60; redir_pct = 5; err_pct = 5; dly_min = 0; dly_max = 3;
    run(2000);

    // Reset while a transaction is open.
    redir_pct = 0; err_pct = 0; force_redir = 1; redir_tgt = 64'h20;
    run(1);
    for (int k = 0; k < 60 && !ram_txs; k++) run(1);
    check("rst_wait_txs", {63'd0, ram_txs}, 64'd1);
    mon_en = 0;
    rst_n = 0;
    #1;
    check("async_rst_txs", {63'd0, ram_txs}, '0);
    check("async_rst_valid", {63'd0, instr_valid}, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1; mon_en = 1; txn_cnt = 0;
    take_pct = 100;
    run(40);
    check("post_rst_fetches", {63'd0, txn_cnt > 0}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
